// File: rtl/rd_req_router.sv
// rd_req_router: routes one slave read-request stream to MASTER_NUM master ports.
// Each destination owns a DEPTH-entry FIFO, so one stalled master never blocks
// traffic headed for the others. Requests with an illegal (zero or multi-hot)
// select are accepted and dropped, and s_err flags the drop on the next cycle.
// Optional feature macro: RD_REQ_ROUTER_STATS_EN adds per-master pop counters
// (stat_cnt) and a synchronous clear input (stat_clr).
module rd_req_router #(
    parameter int AWIDTH     = 32,
    parameter int MASTER_NUM = 2,
    parameter int DEPTH      = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
`ifdef RD_REQ_ROUTER_STATS_EN
    input  logic                                        stat_clr,
    output logic [MASTER_NUM*16-1:0]                    stat_cnt,
`endif
    input  logic                                        s_req,
    input  logic [AWIDTH-1:0]                           s_addr,
    input  logic [MASTER_NUM-1:0]                       s_sel,
    output logic                                        s_ready,
    output logic                                        s_err,
    output logic [MASTER_NUM-1:0]                       m_req,
    output logic [MASTER_NUM*AWIDTH-1:0]                m_addr,
    input  logic [MASTER_NUM-1:0]                       m_full,
    output logic [MASTER_NUM*($clog2(DEPTH)+1)-1:0]     m_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AWIDTH-1:0]     mem    [MASTER_NUM][DEPTH];
    logic [PW-1:0]         wr_ptr [MASTER_NUM];
    logic [PW-1:0]         rd_ptr [MASTER_NUM];
    logic [LW-1:0]         count  [MASTER_NUM];

    logic                  sel_legal;
    logic [MASTER_NUM-1:0] full;
    logic [MASTER_NUM-1:0] push;
    logic [MASTER_NUM-1:0] pop;

    // Decode the select: legal only when exactly one bit is set. The ready answer
    // is taken from the selected FIFO alone so a full neighbour cannot stall us;
    // illegal selects are always accepted so they can be dropped.
    always_comb begin
        sel_legal = (s_sel != '0) && ((s_sel & (s_sel - MASTER_NUM'(1))) == '0);
        s_ready   = sel_legal ? ~|(s_sel & full) : 1'b1;
        push      = (s_req && s_ready && sel_legal) ? s_sel : '0;
        pop       = m_req & ~m_full;
    end

    // Registered drop flag: pulses for one cycle after an illegal request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_err <= 1'b0;
        end else begin
            s_err <= s_req && !sel_legal;
        end
    end

    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_fifo
        assign full[i]                       = (count[i] == LW'(DEPTH));
        assign m_req[i]                      = (count[i] != '0);
        assign m_addr[i*AWIDTH +: AWIDTH]    = mem[i][rd_ptr[i]];
        assign m_level[i*LW +: LW]           = count[i];

        // Per-destination FIFO: storage, wrapping pointers and occupancy count.
        // Storage is cleared on reset so the head address reads as zero afterwards.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= s_addr;
                    wr_ptr[i]         <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + LW'(1);
                    2'b01:   count[i] <= count[i] - LW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end

`ifdef RD_REQ_ROUTER_STATS_EN
        logic [15:0] pops;

        assign stat_cnt[i*16 +: 16] = pops;

        // Saturating pop counter; a clear in the same cycle as a pop wins.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pops <= '0;
            end else if (stat_clr) begin
                pops <= '0;
            end else if (pop[i] && (pops != 16'hFFFF)) begin
                pops <= pops + 16'd1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_rd_req_router.sv
// tb_rd_req_router: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the router.
module tb_rd_req_router;

    localparam int AW    = 32;
    localparam int MN    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_req;
    logic [AW-1:0]      s_addr;
    logic [MN-1:0]      s_sel;
    logic               s_ready;
    logic               s_err;
    logic [MN-1:0]      m_req;
    logic [MN*AW-1:0]   m_addr;
    logic [MN-1:0]      m_full;
    logic [MN*LW-1:0]   m_level;
`ifdef RD_REQ_ROUTER_STATS_EN
    logic               stat_clr;
    logic [MN*16-1:0]   stat_cnt;
`endif

    // Reference model state: one queue per master plus the expected error flag.
    logic [AW-1:0]      mq [MN][$];
    logic               err_exp;
    int                 stat_exp [MN];

    int                 vectors;
    int                 miscompares;

    rd_req_router #(.AWIDTH(AW), .MASTER_NUM(MN), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef RD_REQ_ROUTER_STATS_EN
        .stat_clr(stat_clr),
        .stat_cnt(stat_cnt),
`endif
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_sel   (s_sel),
        .s_ready (s_ready),
        .s_err   (s_err),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_full  (m_full),
        .m_level (m_level)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit sel_is_legal(input logic [MN-1:0] sel);
        return $countones(sel) == 1;
    endfunction

    function automatic int sel_index(input logic [MN-1:0] sel);
        int idx = 0;
        for (int i = 0; i < MN; i++) if (sel[i]) idx = i;
        return idx;
    endfunction

    function automatic logic model_ready();
        if (!sel_is_legal(s_sel)) return 1'b1;
        return (mq[sel_index(s_sel)].size() < DEPTH) ? 1'b1 : 1'b0;
    endfunction

    task automatic check_output();
        check("s_ready", 64'(s_ready), 64'(model_ready()));
        check("s_err", 64'(s_err), 64'(err_exp));
        for (int i = 0; i < MN; i++) begin
            check($sformatf("m_req[%0d]", i), 64'(m_req[i]), 64'(mq[i].size() != 0));
            check($sformatf("m_level[%0d]", i), 64'(m_level[i*LW +: LW]), 64'(mq[i].size()));
            if (mq[i].size() != 0)
                check($sformatf("m_addr[%0d]", i), 64'(m_addr[i*AW +: AW]), 64'(mq[i][0]));
`ifdef RD_REQ_ROUTER_STATS_EN
            check($sformatf("stat_cnt[%0d]", i), 64'(stat_cnt[i*16 +: 16]), 64'(stat_exp[i]));
`endif
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit do_push;
        int dest;
        do_push = s_req && sel_is_legal(s_sel) && model_ready();
        dest    = sel_index(s_sel);
        for (int i = 0; i < MN; i++) begin
            bit popped;
            popped = (mq[i].size() != 0) && !m_full[i];
            if (popped) void'(mq[i].pop_front());
`ifdef RD_REQ_ROUTER_STATS_EN
            if (stat_clr) stat_exp[i] = 0;
            else if (popped && stat_exp[i] < 65535) stat_exp[i]++;
`endif
        end
        if (do_push) mq[dest].push_back(s_addr);
        err_exp = s_req && !sel_is_legal(s_sel);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MN; i++) begin
            mq[i].delete();
            stat_exp[i] = 0;
        end
        err_exp = 1'b0;
    endtask

    task automatic apply_stimulus(input logic req, input logic [AW-1:0] addr,
                                  input logic [MN-1:0] sel, input logic [MN-1:0] full,
                                  input logic clr);
        s_req  = req;
        s_addr = addr;
        s_sel  = sel;
        m_full = full;
`ifdef RD_REQ_ROUTER_STATS_EN
        stat_clr = clr;
`else
        if (clr) $display("[TB] stat_clr ignored, stats disabled");
`endif
        @(negedge clk);
        check_output();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        s_req  = 1'b0;
        s_addr = '0;
        s_sel  = '0;
        m_full = '0;
`ifdef RD_REQ_ROUTER_STATS_EN
        stat_clr = 1'b0;
`endif
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset m_req", 64'(m_req), 64'(0));
        check("reset m_addr", 64'(m_addr), 64'(0));
        check("reset m_level", 64'(m_level), 64'(0));
        check("reset s_err", 64'(s_err), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request, one-cycle latency, retired the next cycle
        $display("[TB] single request");
        apply_stimulus(1'b1, 32'h100, 2'b01, 2'b00, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b01, 2'b00, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b01, 2'b00, 1'b0);

        // Stall master 0 until full; master 1 keeps flowing
        $display("[TB] fill stalled master 0");
        for (int k = 0; k < 5; k++)
            apply_stimulus(1'b1, 32'h10 + 32'(k), 2'b01, 2'b01, 1'b0);
        apply_stimulus(1'b1, 32'h200, 2'b10, 2'b01, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b10, 2'b01, 1'b0);

        // Release master 0 and drain in order
        $display("[TB] drain master 0");
        for (int k = 0; k < 5; k++)
            apply_stimulus(1'b0, 32'h0, 2'b01, 2'b00, 1'b0);

        // Illegal selects are accepted, dropped and flagged
        $display("[TB] illegal selects");
        apply_stimulus(1'b1, 32'h300, 2'b00, 2'b00, 1'b0);
        apply_stimulus(1'b1, 32'h301, 2'b11, 2'b00, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b00, 2'b00, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b00, 2'b00, 1'b0);

        // Level 2 with simultaneous push and pop, then reset mid-burst
        $display("[TB] push and pop together, reset mid-burst");
        apply_stimulus(1'b1, 32'h400, 2'b01, 2'b11, 1'b0);
        apply_stimulus(1'b1, 32'h401, 2'b01, 2'b11, 1'b0);
        apply_stimulus(1'b1, 32'h402, 2'b01, 2'b10, 1'b0);
        apply_stimulus(1'b1, 32'h403, 2'b10, 2'b11, 1'b0);
        apply_stimulus(1'b1, 32'h404, 2'b01, 2'b11, 1'b0);
        s_req = 1'b0;
        rst   = 1'b1;
        #1;
        check("async reset m_req", 64'(m_req), 64'(0));
        check("async reset m_level", 64'(m_level), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply_stimulus(1'b0, 32'h0, 2'b01, 2'b00, 1'b0);

        // Random traffic: first half heavy backpressure, second half light
        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [MN-1:0] sel;
            logic [MN-1:0] full;
            r = $urandom_range(0, 9);
            if (r < 8)      sel = MN'(1) << (r % MN);
            else if (r == 8) sel = '0;
            else            sel = '1;
            for (int i = 0; i < MN; i++)
                full[i] = (n < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            apply_stimulus($urandom_range(0, 3) != 0, AW'($urandom), sel, full,
                           $urandom_range(0, 31) == 0);
        end
        for (int k = 0; k < 6; k++)
            apply_stimulus(1'b0, 32'h0, 2'b01, 2'b00, 1'b0);

`ifdef RD_REQ_ROUTER_STATS_EN
        // Pop counter: clear, three pops on master 1, then clear with a same-cycle pop
        $display("[TB] statistics");
        apply_stimulus(1'b0, 32'h0, 2'b10, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b1, 32'h500 + 32'(k), 2'b10, 2'b00, 1'b0);
        apply_stimulus(1'b1, 32'h510, 2'b10, 2'b00, 1'b0);
        apply_stimulus(1'b0, 32'h0,   2'b10, 2'b00, 1'b1);
        apply_stimulus(1'b0, 32'h0,   2'b10, 2'b00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
